// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central stall/flush controller for the five-stage pipeline. Produces the
//   enable and synchronous-clear controls for the PC and the IF/ID, ID/EX,
//   EX/MEM and MEM/WB pipeline registers. It resolves three hazard types:
//   load-use (one-cycle bubble), taken branch resolved in EX (two-slot
//   squash), and multi-cycle EX operations (front end frozen, bubbles
//   injected into MEM).
//
// Ports
//   Clk, Rst               clock; synchronous active-high reset
//   ID_Rs, ID_Rt,          source registers of the ID instruction; ID_UsesRt
//   ID_UsesRt              qualifies ID_Rt
//   EX_MemRead, EX_Rd      EX instruction is a load / its destination
//   EX_MultiCycle          EX instruction occupies EX for MC_LAT cycles
//   EX_BranchTaken         branch in EX resolved taken
//   *_En                   pipeline register enables
//   *_Flush                pipeline register synchronous clears
//   Busy                   multi-cycle freeze in progress (registered)
//   StallCycles            saturating count of cycles with PC_En low
module pipeline_hazard_ctrl #(
  parameter int RW     = 5,
  parameter int MC_LAT = 4,
  parameter int SCW    = 16
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic [RW-1:0]  ID_Rs,
  input  logic [RW-1:0]  ID_Rt,
  input  logic           ID_UsesRt,
  input  logic           EX_MemRead,
  input  logic [RW-1:0]  EX_Rd,
  input  logic           EX_MultiCycle,
  input  logic           EX_BranchTaken,
  output logic           PC_En,
  output logic           IFID_En,
  output logic           IDEX_En,
  output logic           EXMEM_En,
  output logic           MEMWB_En,
  output logic           IFID_Flush,
  output logic           IDEX_Flush,
  output logic           EXMEM_Flush,
  output logic           Busy,
  output logic [SCW-1:0] StallCycles
);

  localparam int CW = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;
  localparam bit MC_EN = (MC_LAT > 1);
  // The entry cycle is itself a freeze cycle, so BUSY needs MC_LAT-2 more.
  localparam logic [CW-1:0] CNT_INIT = (MC_LAT > 1) ? CW'(MC_LAT - 2) : '0;

  typedef enum logic {RUN, BUSY} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SCW-1:0]  stall_q, stall_d;
  logic            freeze;
  logic            load_use;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    freeze  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (EX_MultiCycle && MC_EN) begin
          freeze  = 1'b1;
          state_d = BUSY;
          cnt_d   = CNT_INIT;
        end
      end
      BUSY: begin
        // EX_MultiCycle is not looked at here, so the release cycle
        // cannot retrigger the freeze.
        if (cnt_q != '0) begin
          freeze = 1'b1;
          cnt_d  = cnt_q - CW'(1);
        end else begin
          state_d = RUN;
        end
      end
    endcase
  end

  always_comb begin
    load_use = EX_MemRead && (EX_Rd != '0) &&
               ((EX_Rd == ID_Rs) || (ID_UsesRt && (EX_Rd == ID_Rt)));

    PC_En       = 1'b1;
    IFID_En     = 1'b1;
    IDEX_En     = 1'b1;
    EXMEM_En    = 1'b1;
    MEMWB_En    = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Flush  = 1'b0;
    EXMEM_Flush = 1'b0;

    if (Rst) begin
      // defaults
    end else if (freeze) begin
      PC_En       = 1'b0;
      IFID_En     = 1'b0;
      IDEX_En     = 1'b0;
      EXMEM_Flush = 1'b1;
    end else if (EX_BranchTaken) begin
      IFID_Flush = 1'b1;
      IDEX_Flush = 1'b1;
    end else if (load_use) begin
      PC_En      = 1'b0;
      IFID_En    = 1'b0;
      IDEX_Flush = 1'b1;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!PC_En && (stall_q != '1)) begin
      stall_d = stall_q + SCW'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign Busy        = (state_q == BUSY);
  assign StallCycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
//   Three controller instances (MC_LAT/SCW = 4/16, 1/16, 3/3) share one
//   stimulus stream. A behavioural model tracks each multi-cycle op by its
//   age in EX and the stall count as a plain saturating integer.
module tb_pipeline_hazard_ctrl;

  localparam int ND = 3;
  localparam int LAT_P [ND] = '{4, 1, 3};
  localparam int SCW_P [ND] = '{16, 16, 3};

  logic       Clk = 1'b0;
  logic       Rst;
  logic [4:0] ID_Rs, ID_Rt, EX_Rd;
  logic       ID_UsesRt, EX_MemRead, EX_MultiCycle, EX_BranchTaken;

  logic [7:0]  ctrl_w [ND];
  logic        busy_w [ND];
  logic [31:0] sc_w   [ND];

  always #5 Clk = ~Clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    logic pc, ifid, idex, exmem, memwb, fifid, fidex, fexmem, busy;
    logic [SCW_P[g]-1:0] sc;

    pipeline_hazard_ctrl #(
      .RW(5),
      .MC_LAT(LAT_P[g]),
      .SCW(SCW_P[g])
    ) u_dut (
      .Clk(Clk),
      .Rst(Rst),
      .ID_Rs(ID_Rs),
      .ID_Rt(ID_Rt),
      .ID_UsesRt(ID_UsesRt),
      .EX_MemRead(EX_MemRead),
      .EX_Rd(EX_Rd),
      .EX_MultiCycle(EX_MultiCycle),
      .EX_BranchTaken(EX_BranchTaken),
      .PC_En(pc),
      .IFID_En(ifid),
      .IDEX_En(idex),
      .EXMEM_En(exmem),
      .MEMWB_En(memwb),
      .IFID_Flush(fifid),
      .IDEX_Flush(fidex),
      .EXMEM_Flush(fexmem),
      .Busy(busy),
      .StallCycles(sc)
    );

    assign ctrl_w[g] = {pc, ifid, idex, exmem, memwb, fifid, fidex, fexmem};
    assign busy_w[g] = busy;
    assign sc_w[g]   = 32'(sc);
  end

  // age: -1 when no multi-cycle op is in EX, otherwise cycles since it entered
  int age    [ND];
  int stalls [ND];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // {PC, IFID, IDEX, EXMEM, MEMWB enables, IFID, IDEX, EXMEM flushes}
  localparam logic [7:0] C_DEF = 8'b1111_1000;
  localparam logic [7:0] C_FRZ = 8'b0001_1001;
  localparam logic [7:0] C_BR  = 8'b1111_1110;
  localparam logic [7:0] C_LU  = 8'b0011_1010;

  task automatic step(input logic rst, input logic mc, input logic br, input logic mr,
                      input logic ut, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd);
    int cur;
    int smax;
    logic frz, lu;
    logic [7:0] e;
    Rst = rst; EX_MultiCycle = mc; EX_BranchTaken = br; EX_MemRead = mr;
    ID_UsesRt = ut; ID_Rs = rs; ID_Rt = rt; EX_Rd = rd;
    @(negedge Clk);
    for (int d = 0; d < ND; d++) begin
      cur = age[d];
      if (!rst && cur < 0 && mc && LAT_P[d] > 1) cur = 0;
      frz = !rst && cur >= 0 && cur <= LAT_P[d] - 2;
      lu  = mr && rd != 5'd0 && (rd == rs || (ut && rd == rt));
      if (rst)      e = C_DEF;
      else if (frz) e = C_FRZ;
      else if (br)  e = C_BR;
      else if (lu)  e = C_LU;
      else          e = C_DEF;
      chk($sformatf("u%0d.ctrl", d), 32'(ctrl_w[d]), 32'(e));
      chk($sformatf("u%0d.busy", d), 32'(busy_w[d]), 32'(age[d] >= 1));
      chk($sformatf("u%0d.stall", d), sc_w[d], 32'(stalls[d]));
      smax = (1 << SCW_P[d]) - 1;
      if (rst) begin
        age[d]    = -1;
        stalls[d] = 0;
      end else begin
        if (!e[7] && stalls[d] < smax) stalls[d]++;
        if (cur >= 0) age[d] = (cur + 1 > LAT_P[d] - 1) ? -1 : cur + 1;
      end
    end
    @(posedge Clk);
    #1;
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin
      age[d]    = -1;
      stalls[d] = 0;
    end
    Rst = 1'b1; EX_MultiCycle = 1'b0; EX_BranchTaken = 1'b0; EX_MemRead = 1'b0;
    ID_UsesRt = 1'b0; ID_Rs = '0; ID_Rt = '0; EX_Rd = '0;
    repeat (2) @(posedge Clk);
    #1;

    // reset state
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    // load-use on Rs, then bubble cycle
    step(0, 0, 0, 1, 0, 5'd7, 5'd0, 5'd7);
    step(0, 0, 0, 0, 0, 5'd7, 5'd0, 5'd7);
    // register 0 and Rt gating
    step(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
    step(0, 0, 0, 1, 0, 5'd1, 5'd9, 5'd9);
    step(0, 0, 0, 1, 1, 5'd1, 5'd9, 5'd9);
    step(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    // multi-cycle op held high
    repeat (5) step(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    step(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    step(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    // branch overriding load-use
    step(0, 0, 1, 1, 0, 5'd7, 5'd0, 5'd7);
    // branch during freeze
    step(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    step(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    repeat (3) step(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    // reset on the second BUSY cycle
    step(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    step(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    step(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    step(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    // sustained load-use for counter saturation
    repeat (10) step(0, 0, 0, 1, 0, 5'd7, 5'd0, 5'd7);
    step(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);

    // randomized traffic with narrow register range to provoke matches
    repeat (500) begin
      step($urandom_range(0, 49) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 5) == 0,
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the five-stage pipeline. Drives the enable and synchronous-clear inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three hazard types: load-use (one-cycle bubble), taken branch resolved in EX (two-slot flush), and multi-cycle EX operations (freeze front end, bubble into MEM). It is the producer of the En/Rst controls that every pipeline register consumes.

## Interface
- RW, 5, register-address width
- MC_LAT, 4, total cycles a multi-cycle op occupies EX (≥1; 1 disables multi-cycle handling)
- SCW, 16, stall-counter width
- Clk  in  1  clock, all state updates on rising edge
- Rst  in  1  synchronous, active-high reset
- ID_Rs  in  RW  source register 1 of the instruction in ID
- ID_Rt  in  RW  source register 2 of the instruction in ID
- ID_UsesRt  in  1  ID instruction reads ID_Rt
- EX_MemRead  in  1  instruction in EX is a load
- EX_Rd  in  RW  destination of the instruction in EX
- EX_MultiCycle  in  1  instruction in EX needs MC_LAT cycles
- EX_BranchTaken  in  1  branch in EX resolved taken
- PC_En, IFID_En, IDEX_En, EXMEM_En, MEMWB_En  out  1 each  register enables
- IFID_Flush, IDEX_Flush, EXMEM_Flush  out  1 each  synchronous clear, wired into the register Rst path (OR-ed with global Rst)
- Busy  out  1  multi-cycle freeze in progress (registered state = BUSY)
- StallCycles  out  SCW  count of cycles with PC_En=0, saturating

## Operation
- Default (no hazard): all En=1, all Flush=0.
- FSM states: RUN, BUSY. Down-counter cnt, width clog2(MC_LAT) (min 1).
- Freeze condition F = (RUN & EX_MultiCycle & MC_LAT>1) | (BUSY & cnt!=0).
- F active: PC_En=IFID_En=IDEX_En=0, EXMEM_Flush=1, MEMWB_En=1; branch and load-use ignored.
- RUN & EX_MultiCycle & MC_LAT>1: next state BUSY, cnt <= MC_LAT-2.
- BUSY & cnt!=0: cnt <= cnt-1. BUSY & cnt==0: release cycle (no freeze), next state RUN.
- EX_MultiCycle is ignored in BUSY (no retrigger in release cycle).
- Taken branch (not F): PC_En=1, IFID_Flush=1, IDEX_Flush=1. Overrides load-use.
- Load-use (not F, no branch): EX_MemRead & EX_Rd!=0 & (EX_Rd==ID_Rs | (ID_UsesRt & EX_Rd==ID_Rt)) → PC_En=0, IFID_En=0, IDEX_Flush=1; EXMEM/MEMWB advance.
- Register 0 never causes a load-use stall.
- Priority: Rst > freeze > branch > load-use > default.
- StallCycles increments on every edge where PC_En=0 and Rst=0; holds at 2^SCW-1.

## Timing
- All En/Flush outputs are combinational from inputs and registered state, valid the same cycle.
- Reset: state RUN, cnt 0, Busy 0, StallCycles 0. While Rst=1, outputs are forced to default (all En=1, Flush=0).
- Rst mid-BUSY: state RUN on the next cycle, with no residual freeze.
- Load-use costs exactly 1 stall cycle. The hazard clears on the following cycle because the bubble sits in EX.
- Multi-cycle op: MC_LAT-1 consecutive freeze cycles starting with the cycle it enters EX. It advances to MEM on the MC_LAT-th edge.
- Busy rises one cycle after detection and falls after the release cycle.
- Taken branch: 2 wrong-path slots squashed, 0 stall cycles.

## Test plan
- Load-use: EX_MemRead=1, EX_Rd=7, ID_Rs=7 → one cycle of PC_En=0, IFID_En=0, IDEX_Flush=1; next cycle all default; StallCycles=1.
- Reg-0 / Rt gating: EX_Rd=0 with ID_Rs=0 → no stall. EX_Rd=9, ID_Rt=9, ID_UsesRt=0 → no stall; ID_UsesRt=1 → stall.
- Multi-cycle, MC_LAT=4: EX_MultiCycle held high → freeze for 3 cycles (EXMEM_Flush=1 each), release on cycle 4, Busy high on cycles 2–4; StallCycles=3. Repeat with MC_LAT=1 → no freeze.
- Branch vs load-use: EX_BranchTaken=1 together with a load-use match → IFID_Flush=IDEX_Flush=1, PC_En=1. EX_BranchTaken=1 during freeze → ignored.
- Reset mid-operation: assert Rst on the 2nd BUSY cycle → next cycle RUN, Busy=0, StallCycles=0, outputs default.
- Saturation: SCW=3, hold a load-use condition for 10 cycles → StallCycles stops at 7.
